approx_adder_error_monitor: RTL and testbench
=============================================

# approx_adder_error_monitor

- Sequential evaluation harness for generated approximate adder netlists, such as the 2-bit SubXPAT `adder_i*_o*` family.
- Drives every input vector into the attached combinational approximate circuit and reads back its outputs.
- Compares each output against the exact sum and reports the error count, the maximum absolute error, the first failing vector, and pass/fail against the error threshold ET.
- Sits on the driving/consuming side of the approximate netlist, as its on-chip checker.

## Interface
Parameters:
- IN_BITS, 4, total DUT input width; even. Operand a = vec[IN_BITS/2-1:0], operand b = vec[IN_BITS-1:IN_BITS/2].
- OUT_BITS, 3, DUT output width; must equal IN_BITS/2+1.
- ET, 0, error threshold; pass when max_err <= ET.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- dut_in  out  IN_BITS  registered vector to the DUT inputs (in0 = bit 0).
- dut_out  in  OUT_BITS  DUT outputs (out0 = bit 0); combinational from dut_in.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the results are final.
- pass  out  1  max_err <= ET; valid from done until the next start.
- err_count  out  IN_BITS+1  number of vectors with a nonzero error.
- max_err  out  OUT_BITS  largest absolute error seen.
- first_fail_vec  out  IN_BITS  lowest-index failing vector.
- first_fail_valid  out  1  at least one vector failed.
- Reset value of every output: 0.

## Operation
FSM states and transitions:
- IDLE: start=1 -> RUN. On entry to RUN, clear dut_in, err_count, max_err, first_fail_vec, first_fail_valid and pass.
- RUN: dut_in increments by 1 each cycle. When dut_in reaches 2^IN_BITS-1, go to FLUSH.
- FLUSH: one cycle that processes the last sample -> DONE.
- DONE: one cycle; done=1 and pass is computed -> IDLE. Results are held until the next start.

Sample stage, every RUN cycle:
- Register vec_q <= dut_in, out_q <= dut_out and v_q <= 1.
- In FLUSH, v_q is still 1 for the final vector; it clears afterwards.

Accumulate stage, when v_q=1:
- exact = a + b, OUT_BITS wide, no overflow by construction.
- err = |out_q - exact|, OUT_BITS wide, unsigned.
- If err != 0: err_count += 1, and if first_fail_valid=0, capture first_fail_vec <= vec_q and set first_fail_valid.
- max_err <= max(max_err, err).

Boundary conditions:
- start while busy or in DONE: ignored.
- rst at any cycle: everything returns to IDLE with zeroed outputs next edge; no partial done.
- start held high continuously: a new sweep begins in the cycle after DONE.
- err_count saturation is impossible; the width is sized for 2^IN_BITS.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1..2^IN_BITS (RUN): dut_in = 0..2^IN_BITS-1; busy=1.
- Cycle 2^IN_BITS+1: FLUSH, busy=1.
- Cycle 2^IN_BITS+2: DONE, done=1, busy=0. Total latency is 18 cycles for IN_BITS=4.
- The DUT combinational path from dut_in to dut_out must settle within one clk period.
- Results are held after done; pass is meaningful only after done.

## Structure
- Package approx_eval_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - a function exact_sum(vec) with the operand-split rule;
  - localparam N_VEC = 2**IN_BITS.
- One sub-module: approx_err_calc, combinational (vec, approx) -> err, holding the exact-sum and absolute-difference logic. It is reusable for multiplier benches later.
- The top-level holds the FSM, the vector counter, the sample registers and the accumulators.

## Test plan
- Exact adder DUT (dut_out = a+b), ET=0 -> done at cycle 18, err_count=0, max_err=0, first_fail_valid=0, pass=1.
- DUT stuck at 0 -> err_count=15, max_err=6, first_fail_vec=1, pass=0.
- DUT with out2 forced to 0 -> err_count=6, max_err=4, first_fail_vec=7, pass=0.
- DUT = (a+b+1) mod 8 with ET=1 -> err_count=16, max_err=1, first_fail_vec=0, pass=1.
- rst pulsed at cycle 5, start reissued at cycle 8 -> all outputs 0 at cycle 6; fresh sweep completes with done at cycle 26 and correct results.
- start pulsed again at cycles 3 and 10 during a sweep -> ignored; done still at cycle 18 and exactly one done pulse.

Source files
------------

// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-circuit evaluation harness.
package approx_eval_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam int DEF_IN_BITS = 4;
  localparam int N_VEC       = 2**DEF_IN_BITS;

  // Low half of the vector is operand a, high half is operand b.
  function automatic int unsigned exact_sum(input int unsigned vec, input int unsigned in_bits);
    int unsigned half;
    int unsigned mask;
    half = in_bits / 2;
    mask = (32'd1 << half) - 32'd1;
    return (vec & mask) + ((vec >> half) & mask);
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Absolute error of an approximate result against the exact operand sum.
module approx_err_calc
  import approx_eval_pkg::*;
#(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 3
) (
  input  logic [IN_BITS-1:0]  vec_i,
  input  logic [OUT_BITS-1:0] approx_i,
  output logic [OUT_BITS-1:0] err_o
);

  logic [OUT_BITS-1:0] exact;

  always_comb begin
    exact = OUT_BITS'(exact_sum(32'(vec_i), IN_BITS));
    err_o = (approx_i >= exact) ? (approx_i - exact) : (exact - approx_i);
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Sweeps every input vector through an attached approximate adder and
// accumulates error count, max error and the first failing vector.
module approx_adder_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 3,
  parameter int ET       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IN_BITS-1:0]  dut_in,
  input  logic [OUT_BITS-1:0] dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IN_BITS:0]    err_count,
  output logic [OUT_BITS-1:0] max_err,
  output logic [IN_BITS-1:0]  first_fail_vec,
  output logic                first_fail_valid
);

  localparam logic [IN_BITS-1:0] LAST_VEC = '1;

  state_e              state_q, state_d;
  logic [IN_BITS-1:0]  dut_in_q;
  logic [IN_BITS-1:0]  vec_q;
  logic [OUT_BITS-1:0] out_q;
  logic                v_q;
  logic [IN_BITS:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] max_q, max_d;
  logic [IN_BITS-1:0]  ffv_q, ffv_d;
  logic                ffval_q, ffval_d;
  logic                pass_q, pass_d;
  logic [OUT_BITS-1:0] err;
  logic                sweep_go;

  assign sweep_go = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (dut_in_q == LAST_VEC) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sample stage: one-cycle delay so the DUT path gets a full period to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in_q <= '0;
      vec_q    <= '0;
      out_q    <= '0;
      v_q      <= 1'b0;
    end else begin
      v_q <= (state_q == RUN);
      if (state_q == RUN) begin
        vec_q <= dut_in_q;
        out_q <= dut_out;
      end
      if (sweep_go)
        dut_in_q <= '0;
      else if (state_q == RUN && dut_in_q != LAST_VEC)
        dut_in_q <= dut_in_q + 1'b1;
    end
  end

  approx_err_calc #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_err (
    .vec_i    (vec_q),
    .approx_i (out_q),
    .err_o    (err)
  );

  always_comb begin
    cnt_d   = cnt_q;
    max_d   = max_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    pass_d  = pass_q;
    if (sweep_go) begin
      cnt_d   = '0;
      max_d   = '0;
      ffv_d   = '0;
      ffval_d = 1'b0;
      pass_d  = 1'b0;
    end else begin
      if (v_q) begin
        if (err != '0) begin
          cnt_d = cnt_q + 1'b1;
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        if (err > max_q) max_d = err;
      end
      // FLUSH folds in the last sample, so max_d is final here.
      if (state_q == FLUSH) pass_d = (int'(max_d) <= ET);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      max_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = (state_q == RUN) || (state_q == FLUSH);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_count        = cnt_q;
  assign max_err          = max_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Scoreboard bench: two monitors (ET=0 and ET=1) watch the same table-driven adder model.
module tb_approx_adder_error_monitor;

  localparam int IB = 4;
  localparam int OB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic [IB-1:0] din0, din1, ffv0, ffv1;
  logic [OB-1:0] dout0, dout1, max0, max1;
  logic [IB:0]   cnt0, cnt1;
  logic busy0, done0, pass0, ffval0;
  logic busy1, done1, pass1, ffval1;

  int tbl [16];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cnt; int mx; int ffv; int ffval; int p0; int p1; int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dout0 = OB'(tbl[din0]);
  assign dout1 = OB'(tbl[din1]);

  approx_adder_error_monitor #(.IN_BITS(IB), .OUT_BITS(OB), .ET(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .dut_in(din0), .dut_out(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(cnt0), .max_err(max0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  approx_adder_error_monitor #(.IN_BITS(IB), .OUT_BITS(OB), .ET(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1), .max_err(max1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: walk all vectors with plain arithmetic over the behaviour table.
  function automatic exp_t model(int start_cyc);
    exp_t r;
    r = '{cnt: 0, mx: 0, ffv: 0, ffval: 0, p0: 0, p1: 0, cyc: start_cyc + 18};
    for (int v = 0; v < 16; v++) begin
      int ex, er;
      ex = (v % 4) + (v / 4);
      er = (tbl[v] > ex) ? tbl[v] - ex : ex - tbl[v];
      if (er != 0) begin
        r.cnt++;
        if (r.ffval == 0) begin r.ffv = v; r.ffval = 1; end
      end
      if (er > r.mx) r.mx = er;
    end
    r.p0 = (r.mx <= 0) ? 1 : 0;
    r.p1 = (r.mx <= 1) ? 1 : 0;
    return r;
  endfunction

  // mode 0 exact, 1 stuck-0, 2 out2 forced 0, 3 +1 mod 8, 4 random corruption, 5 random +0/+1
  task automatic setup(int m);
    for (int v = 0; v < 16; v++) begin
      int s;
      s = (v % 4) + (v / 4);
      case (m)
        0: tbl[v] = s;
        1: tbl[v] = 0;
        2: tbl[v] = s % 4;
        3: tbl[v] = (s + 1) % 8;
        4: tbl[v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : s;
        default: tbl[v] = s + int'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep();
    start = 1'b1;
    q.push_back(model(cyc));
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", busy0, 0);
        chk("err_count", cnt0, e.cnt);
        chk("max_err", max0, e.mx);
        chk("first_fail_vec", ffv0, e.ffv);
        chk("first_fail_valid", ffval0, e.ffval);
        chk("pass_et0", pass0, e.p0);
        chk("done_et1", done1, 1);
        chk("err_count_et1", cnt1, e.cnt);
        chk("pass_et1", pass1, e.p1);
      end
    end
  end

  initial begin
    int s;
    setup(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err_count", cnt0, 0);
    chk("rst_max_err", max0, 0);
    chk("rst_ffv", ffv0, 0);
    chk("rst_ffval", ffval0, 0);
    chk("rst_dut_in", din0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      setup(m);
      sweep();
    end
    for (int i = 0; i < 8; i++) begin
      setup(4 + (i % 2));
      sweep();
    end

    // Reset mid-sweep, then a fresh start three cycles later.
    setup(1);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 5);
    chk("mid_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rrst_busy", busy0, 0);
    chk("rrst_err_count", cnt0, 0);
    chk("rrst_ffval", ffval0, 0);
    chk("rrst_dut_in", din0, 0);
    wait_until(s + 8);
    sweep();

    // Extra start pulses during a sweep must be ignored.
    setup(2);
    s = cyc;
    start = 1'b1;
    q.push_back(model(cyc));
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: back-to-back sweeps.
    setup(5);
    s = cyc;
    start = 1'b1;
    q.push_back(model(s));
    q.push_back(model(s + 19));
    wait_until(s + 25);
    start = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
